// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns fetch_pc, drives the imem req/ack port, buffers words in a prefetch queue.
// Define FETCH_STATS_EN to add the fetch_count / flush_count outputs.
module instruction_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [15:0] instr_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0] fetch_count,
   output logic [7:0]  flush_count
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } state_t;

   state_t state, state_n;

   logic [15:0]   fetch_pc;
   logic [15:0]   disc_addr;
   logic [15:0]   q_instr [DEPTH];
   logic [15:0]   q_pc    [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          fill;

   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready;
   assign push        = (state == REQ) & imem_ack & ~redirect;
   assign fill        = (count == FULL) | ((count == ALMOST) & push & ~pop);

   assign imem_req  = (state != IDLE);
   // a discarded request must keep its original address until acked
   assign imem_addr = (state == DISCARD) ? disc_addr : fetch_pc;
   assign instr     = instr_valid ? q_instr[rd_ptr] : 16'h0000;
   assign instr_pc  = instr_valid ? q_pc[rd_ptr] : 16'h0000;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (redirect || count < FULL)
               state_n = REQ;
         end
         REQ: begin
            if (redirect)
               state_n = imem_ack ? REQ : DISCARD;
            else if (imem_ack && fill)
               state_n = IDLE;
         end
         DISCARD: begin
            if (imem_ack)
               state_n = redirect ? IDLE : REQ;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         disc_addr <= RESET_PC;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state <= state_n;
         if (redirect) begin
            fetch_pc <= redirect_pc & 16'hFFFE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            if (state == REQ && !imem_ack)
               disc_addr <= fetch_pc;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 16'd2;
               wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
               count <= count + CW'(1);
            else if (pop && !push)
               count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= 16'h0000;
            q_pc[i]    <= 16'h0000;
         end
      end else if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= fetch_pc;
      end
   end

`ifdef FETCH_STATS_EN
   logic lost;

   // words popped in the redirect cycle were accepted, so they do not count as lost
   assign lost = (count != CW'(pop)) | (state == REQ);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_count <= 16'h0000;
         flush_count <= 8'h00;
      end else begin
         if (pop)
            fetch_count <= fetch_count + 16'd1;
         if (redirect && lost && flush_count != 8'hFF)
            flush_count <= flush_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit against a transaction-level queue model.
// Define FETCH_STATS_EN to also check the statistics counters.
module tb_instruction_fetch_unit;

   localparam int DEPTH = 4;
   localparam logic [15:0] RPC = 16'hFFFC;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;
`ifdef FETCH_STATS_EN
   logic [15:0] fetch_count;
   logic [7:0]  flush_count;
`endif

   always #5 clock = ~clock;

   instruction_fetch_unit #(
      .DEPTH(DEPTH),
      .RESET_PC(RPC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count(fetch_count),
      .flush_count(flush_count)
`endif
   );

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   assign imem_rdata = memf(imem_addr);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // model: queue of {data, pc} that decode should see, in order
   logic [31:0] q[$];
   logic [15:0] exp_fetch;
   logic        stale;
   logic [15:0] stale_addr;
   logic        first;
   logic        prev_req;
   logic        prev_redir;
   int          prev_size;
   int          fcnt;
   int          flcnt;

   task automatic model_reset();
      q.delete();
      exp_fetch  = RPC;
      stale      = 1'b0;
      stale_addr = RPC;
      first      = 1'b1;
      prev_req   = 1'b0;
      prev_redir = 1'b0;
      prev_size  = 0;
      fcnt       = 0;
      flcnt      = 0;
   endtask

   task automatic step(input logic a, input logic r, input logic rd,
                       input logic [15:0] rpc);
      logic        er;
      logic        v;
      logic [31:0] head;
      int          sz;
      if (stale)
         rd = 1'b0;
      @(negedge clock);
      imem_ack    = a;
      instr_ready = r;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      sz = q.size();
      v  = (sz != 0);
      head = 32'h0;
      if (v)
         head = q[0];
      if (stale)
         er = 1'b1;
      else if (first)
         er = 1'b0;
      else
         er = (sz < DEPTH) && (prev_req || prev_redir || prev_size < DEPTH);
      chk("req", 32'(imem_req), 32'(er));
      if (er)
         chk("addr", 32'(imem_addr), 32'(stale ? stale_addr : exp_fetch));
      chk("valid", 32'(instr_valid), 32'(v));
      chk("instr", 32'(instr), 32'(head[31:16]));
      chk("instr_pc", 32'(instr_pc), 32'(head[15:0]));
      @(posedge clock);
      prev_req   = er;
      prev_redir = rd;
      prev_size  = sz;
      first      = 1'b0;
      if (v && r) begin
         fcnt++;
         void'(q.pop_front());
      end
      if (rd) begin
         if (q.size() != 0 || (er && !stale))
            flcnt = (flcnt < 255) ? flcnt + 1 : 255;
         q.delete();
         if (er && !a) begin
            stale      = 1'b1;
            stale_addr = exp_fetch;
         end
         exp_fetch = rpc & 16'hFFFE;
      end else if (er && a) begin
         if (stale) begin
            stale = 1'b0;
         end else begin
            q.push_back({memf(exp_fetch), exp_fetch});
            exp_fetch = exp_fetch + 16'd2;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'(RPC));
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_instr"}, 32'(instr), 32'd0);
      chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
`ifdef FETCH_STATS_EN
      chk({tag, "_fcnt"}, 32'(fetch_count), 32'd0);
      chk({tag, "_flcnt"}, 32'(flush_count), 32'd0);
`endif
   endtask

   initial begin
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      reset       = 1'b1;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk_reset_outputs("rst");
      reset = 1'b0;

      // streaming, wraps FFFC -> 0000
      repeat (12) step(1'b1, 1'b1, 1'b0, 16'h0);
      // decode stalled: queue fills, request drops
      repeat (8) step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0);
      // drain with memory stalled, then redirect a pending request
      repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b0, 1'b1, 16'h0041);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0);
      repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0);
      // three queued, then redirect with coincident ack and pop
      repeat (5) step(1'b0, 1'b1, 1'b0, 16'h0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b1, 16'h1234);
      repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0);
      // redirect near the top of the address space
      step(1'b1, 1'b1, 1'b1, 16'hFFFB);
      repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0, 16'($urandom));

`ifdef FETCH_STATS_EN
      chk("fetch_count", 32'(fetch_count), 32'(fcnt & 16'hFFFF));
      chk("flush_count", 32'(flush_count), 32'(flcnt));
`endif

      // reset while a request is outstanding
      repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      repeat (8) step(1'b1, 1'b1, 1'b0, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
